// File: rtl/memory_out_sink_pkg.sv
// Shared definitions for the CNN result capture buffer.
//   Default geometry (WIDTH/DEPTH/log2_DEPTH) and the legacy FSM state encodings.
package memory_out_sink_pkg;

  localparam int WIDTH_DEF      = 256;
  localparam int DEPTH_DEF      = 8;
  localparam int LOG2_DEPTH_DEF = 3;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_CAPTURE = 1'b1;

endpackage

// File: rtl/sdp_ram_rf.sv
// Simple dual-port register array: one write port, one registered read port.
//   clk, rst_n         : clock / async active-low reset (read register only)
//   wr_en, wr_addr, wr_dat : write port
//   rd_en, rd_addr     : read request; rd_dat updates one cycle later, holds otherwise
// Read-first: a read and a write to the same address in one cycle return the old word.
module sdp_ram_rf #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array has no reset so it survives a mid-burst reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Separate block from the write; non-blocking update gives read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/memory_out_sink.sv
// Capture buffer at the result end of the CNN datapath.
//   start/num_of_dat : arm capture of a burst of num_of_dat+1 words
//   dat_in/dat_in_vld: valid-only input stream, always accepted
//   busy             : high while capturing
//   done             : one-cycle pulse after the last word is written
//   overflow         : sticky, data arrived while idle; cleared by start
//   wr_cnt           : next address to be written
//   rd_en/rd_addr    : host readback; rd_dat/rd_dat_vld follow one cycle later
module memory_out_sink
  import memory_out_sink_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int log2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [log2_DEPTH-1:0] num_of_dat,
  input  logic [WIDTH-1:0]      dat_in,
  input  logic                  dat_in_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [log2_DEPTH-1:0] wr_cnt,
  input  logic                  rd_en,
  input  logic [log2_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat,
  output logic                  rd_dat_vld
);

  state_t                state;
  logic [log2_DEPTH-1:0] last_q;
  logic                  wr_en;

  // Data coinciding with start is dropped, hence the !start term.
  always_comb begin
    busy  = (state == ST_CAPTURE);
    wr_en = (state == ST_CAPTURE) && dat_in_vld && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_q     <= '0;
      wr_cnt     <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      rd_dat_vld <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_dat_vld <= rd_en;
      if (start) begin
        state    <= ST_CAPTURE;
        last_q   <= num_of_dat;
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end else if (dat_in_vld) begin
        if (state == ST_CAPTURE) begin
          if (wr_cnt == last_q) begin
            wr_cnt <= '0;
            state  <= ST_IDLE;
            done   <= 1'b1;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  sdp_ram_rf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(log2_DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_cnt),
    .wr_dat (dat_in),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_dat (rd_dat)
  );

endmodule
